// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic light controller, the night-mode blinker
// and the lamp drivers; clock and reset stay outside as plain ports.
interface traffic_light_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             night_en;
  logic             nm_yellow_a;
  logic             nm_yellow_b;
  logic             laneA_red;
  logic             laneA_yellow;
  logic             laneA_green;
  logic             laneB_red;
  logic             laneB_yellow;
  logic             laneB_green;
  logic [CNT_W-1:0] countdown;
  logic             night_active;

  modport master (
    output night_en, nm_yellow_a, nm_yellow_b,
    input  laneA_red, laneA_yellow, laneA_green,
    input  laneB_red, laneB_yellow, laneB_green,
    input  countdown, night_active
  );

  modport slave (
    input  night_en, nm_yellow_a, nm_yellow_b,
    output laneA_red, laneA_yellow, laneA_green,
    output laneB_red, laneB_yellow, laneB_green,
    output countdown, night_active
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-lane traffic light controller: fixed day cycle from a per-phase
// countdown, plus safe entry into and exit from blinker-driven night mode.
module traffic_light_ctrl #(
  parameter int GREEN_A_S = 25,
  parameter int GREEN_B_S = 20,
  parameter int YELLOW_S  = 3,
  parameter int ALLRED_S  = 2,
  parameter int CNT_W     = 6
) (
  input  logic                 clk_1hz,
  input  logic                 reset,
  traffic_light_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    AG    = 3'd0,
    AY    = 3'd1,
    AR    = 3'd2,
    BG    = 3'd3,
    BY    = 3'd4,
    BR    = 3'd5,
    NIGHT = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_GREEN_A = CNT_W'(GREEN_A_S - 1);
  localparam logic [CNT_W-1:0] LD_GREEN_B = CNT_W'(GREEN_B_S - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(YELLOW_S - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED  = CNT_W'(ALLRED_S - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_tmr;
  logic             w_expired;

  assign w_expired = (r_tmr == '0);

  // A night request cuts a green short, but yellow and all-red always finish,
  // so night mode is only ever entered from an all-red clearance.
  always_ff @(posedge clk_1hz or negedge reset) begin
    if (!reset) begin
      r_state <= BR;
      r_tmr   <= LD_ALLRED;
    end else begin
      case (r_state)
        AG: begin
          if (bus.night_en || w_expired) begin
            r_state <= AY;
            r_tmr   <= LD_YELLOW;
          end else begin
            r_tmr <= r_tmr - CNT_W'(1);
          end
        end
        AY: begin
          if (w_expired) begin
            r_state <= AR;
            r_tmr   <= LD_ALLRED;
          end else begin
            r_tmr <= r_tmr - CNT_W'(1);
          end
        end
        AR: begin
          if (w_expired && bus.night_en) begin
            r_state <= NIGHT;
            r_tmr   <= '0;
          end else if (w_expired) begin
            r_state <= BG;
            r_tmr   <= LD_GREEN_B;
          end else begin
            r_tmr <= r_tmr - CNT_W'(1);
          end
        end
        BG: begin
          if (bus.night_en || w_expired) begin
            r_state <= BY;
            r_tmr   <= LD_YELLOW;
          end else begin
            r_tmr <= r_tmr - CNT_W'(1);
          end
        end
        BY: begin
          if (w_expired) begin
            r_state <= BR;
            r_tmr   <= LD_ALLRED;
          end else begin
            r_tmr <= r_tmr - CNT_W'(1);
          end
        end
        BR: begin
          if (w_expired && bus.night_en) begin
            r_state <= NIGHT;
            r_tmr   <= '0;
          end else if (w_expired) begin
            r_state <= AG;
            r_tmr   <= LD_GREEN_A;
          end else begin
            r_tmr <= r_tmr - CNT_W'(1);
          end
        end
        NIGHT: begin
          if (!bus.night_en) begin
            r_state <= BR;
            r_tmr   <= LD_ALLRED;
          end else begin
            r_tmr <= '0;
          end
        end
        default: begin
          r_state <= BR;
          r_tmr   <= LD_ALLRED;
        end
      endcase
    end
  end

  // Lamps follow the state register directly; only NIGHT looks at the blinker.
  always_comb begin
    bus.laneA_red    = 1'b0;
    bus.laneA_yellow = 1'b0;
    bus.laneA_green  = 1'b0;
    bus.laneB_red    = 1'b0;
    bus.laneB_yellow = 1'b0;
    bus.laneB_green  = 1'b0;
    case (r_state)
      AG: begin
        bus.laneA_green = 1'b1;
        bus.laneB_red   = 1'b1;
      end
      AY: begin
        bus.laneA_yellow = 1'b1;
        bus.laneB_red    = 1'b1;
      end
      BG: begin
        bus.laneA_red   = 1'b1;
        bus.laneB_green = 1'b1;
      end
      BY: begin
        bus.laneA_red    = 1'b1;
        bus.laneB_yellow = 1'b1;
      end
      NIGHT: begin
        bus.laneA_yellow = bus.nm_yellow_a;
        bus.laneB_yellow = bus.nm_yellow_b;
      end
      default: begin
        bus.laneA_red = 1'b1;
        bus.laneB_red = 1'b1;
      end
    endcase
  end

  assign bus.night_active = (r_state == NIGHT);
  assign bus.countdown    = (r_state == NIGHT) ? '0 : r_tmr + CNT_W'(1);

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Two-lane traffic light controller that sits directly downstream of the night-mode blinker. In day mode it runs the fixed green/yellow/all-red cycle for lanes A and B from its own per-second countdown. In night mode it routes the blinker's yellow outputs (`laneA_yellow`, `laneB_yellow` of `night_mode`) to the lamps. It also drives the seconds-remaining display and enforces safe entry into and exit from night mode.

## Interface
- `GREEN_A_S`, 25: lane A green duration, in cycles (seconds).
- `GREEN_B_S`, 20: lane B green duration, in cycles.
- `YELLOW_S`, 3: yellow duration for either lane, in cycles.
- `ALLRED_S`, 2: all-red clearance duration, in cycles.
- `CNT_W`, 6: width of the countdown register and the `countdown` output. All durations must be ≥1 and ≤2^CNT_W−1.

Ports:
- `clk_1hz`  in  1  1 Hz system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `night_en`  in  1  night-mode request, level-sensitive, synchronous to `clk_1hz`.
- `nm_yellow_a`  in  1  lane A blink from the night-mode blinker.
- `nm_yellow_b`  in  1  lane B blink from the night-mode blinker.
- `laneA_red`, `laneA_yellow`, `laneA_green`  out  1 each  lane A lamps.
- `laneB_red`, `laneB_yellow`, `laneB_green`  out  1 each  lane B lamps.
- `countdown`  out  CNT_W  seconds remaining in the current phase; 0 in night mode.
- `night_active`  out  1  high while in the NIGHT state.

## Operation
- The FSM has seven states:
  - `AG`: A green, B red.
  - `AY`: A yellow, B red.
  - `AR`: all red, before B's green.
  - `BG`: B green, A red.
  - `BY`: B yellow, A red.
  - `BR`: all red, before A's green.
  - `NIGHT`.
- Phase timer `tmr` (CNT_W bits):
  - Loaded with duration−1 on entry to a phase.
  - Decrements by 1 each cycle.
  - The phase ends on the edge where `tmr == 0`; on that edge the next phase's duration−1 is loaded.
  - `countdown = tmr + 1` in day states; 0 in NIGHT.
- Day sequence: `BR` → `AG` → `AY` → `AR` → `BG` → `BY` → `BR`. The period is GREEN_A_S+GREEN_B_S+2·YELLOW_S+2·ALLRED_S cycles (55 at defaults).
- Night entry (`night_en` sampled on every edge):
  - In `AG`/`BG` with `night_en=1`: green is cut short; next state is that lane's yellow with the full YELLOW_S.
  - In `AY`/`BY`: the yellow always runs to completion, then goes to all-red.
  - At `AR`/`BR` expiry with `night_en=1`: next state is `NIGHT`. With `night_en=0`: the normal next green.
  - If `night_en` drops after a green was cut, the sequence continues normally. There is no return to green.
- In NIGHT:
  - `laneA_yellow = nm_yellow_a` and `laneB_yellow = nm_yellow_b`, combinational pass-through (the blinker outputs are already registered on `clk_1hz`).
  - All red and green lamps are 0.
  - `tmr` is held at 0.
- Night exit: `night_en=0` in NIGHT → next edge goes to `BR` (all red, ALLRED_S), then to `AG`.
- Lamp outputs are decoded combinationally from the state register.
  - In every day state, exactly one lamp per lane is on.
  - Both greens are never on together, and a green is never on in NIGHT.
- The nm inputs are ignored outside NIGHT.

## Timing
- Reset asserted (`reset=0`), asynchronously and immediately:
  - State is `BR` with `tmr = ALLRED_S−1`.
  - `laneA_red=1`, `laneB_red=1`; all other lamps 0.
  - `countdown = ALLRED_S`; `night_active=0`.
- Reset mid-operation, including in NIGHT: the same values appear immediately and the outputs leave NIGHT pass-through at once.
- The first rising edge after reset release performs the first decrement. `AG` begins after ALLRED_S edges.
- Lamp, `countdown` and `night_active` changes all occur on the same edge as the state/`tmr` update.
- `night_en` latency:
  - One edge from a green to its yellow.
  - In the worst case, YELLOW_S+ALLRED_S+1 edges from the request to NIGHT.
- Exit latency: one edge to `BR`, then ALLRED_S edges to `AG`.
- Timer wrap: `tmr` never decrements below 0. The load at expiry takes priority, so `tmr` cannot wrap.

## Test plan
- **Free-run:** release reset with `night_en=0`. Required response:
  - Cycles 0–1: all red, `countdown` 2,1.
  - Cycles 2–26: A green, `countdown` 25→1.
  - Cycles 27–29: A yellow, 3→1.
  - Cycles 30–31: all red.
  - Cycles 32–51: B green, 20→1.
  - Cycles 52–54: B yellow.
  - Cycles 55–56: all red.
  - Cycle 57: A green again.
- **Night entry from green:**
  - Stimulus: assert `night_en` while A green at `countdown=17`.
  - Required: the next edge gives A yellow with `countdown=3`; then 3 yellow cycles, then 2 all-red cycles, then `night_active=1`, `countdown=0`.
- **Night pass-through:**
  - Stimulus: in NIGHT, drive `nm_yellow_a`/`nm_yellow_b` = 1,0,1,0 on successive cycles.
  - Required: `laneA_yellow` and `laneB_yellow` follow the inputs in the same cycle; all red and green lamps stay 0.
- **Night exit:**
  - Stimulus: drop `night_en` in NIGHT.
  - Required: the next edge gives all red with `countdown=2`; then A green with `countdown=25`.
- **Cancelled request:**
  - Stimulus: pulse `night_en` for one cycle during B green.
  - Required: B yellow (3 cycles), then all red (2), then A green with `countdown=25`; `night_active` stays 0.
- **Reset mid-phase:**
  - Stimulus: pull `reset` low during B green and again during NIGHT, both between clock edges.
  - Required: outputs immediately show both reds, `countdown=2`, `night_active=0`; the sequence restarts as in the free-run case on release.
